edge_threshold: RTL

- Stage directly downstream of the edge-detect pipeline's output FIFO.
- Pops 8-bit Sobel magnitudes in raster order and binarises each against a per-frame threshold.
- Forces image-border pixels to background and counts edge pixels per frame.
- Pushes the binary image into the next FIFO and pulses a frame-complete strobe with the frame's edge count.

---
 rtl/edge_pkg.sv | 19 +
 rtl/raster_counter.sv | 45 ++++
 rtl/edge_threshold.sv | 124 ++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types and helpers for the edge threshold stage
// Contents: state_t (frame FSM states), default output levels, is_border().
package edge_pkg;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_BODY  = 1'b1
    } state_t;

    localparam logic [7:0] DEFAULT_HIGH_VAL = 8'hFF;
    localparam logic [7:0] DEFAULT_LOW_VAL  = 8'h00;

    // True for pixels on the outer ring of an h x w image.
    function automatic logic is_border(input int unsigned row, input int unsigned col,
                                       input int unsigned h, input int unsigned w);
        return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - row/column position tracker for a raster-order pixel stream
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   adv          : advance one pixel position
//   row, col     : position of the next pixel to be accepted
//   last         : current position is the final pixel of the frame
module raster_counter #(
    parameter int IMG_HEIGHT = 540,
    parameter int IMG_WIDTH  = 720,
    localparam int ROW_W     = $clog2(IMG_HEIGHT),
    localparam int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic row_end;
    logic col_end;

    assign row_end = (row == ROW_LAST);
    assign col_end = (col == COL_LAST);
    assign last    = row_end & col_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/edge_threshold.sv
// rtl/edge_threshold.sv - binarises Sobel magnitudes against a per-frame threshold
// Ports:
//   clock, reset                 : clock and synchronous active-high reset
//   in_rd_en, in_empty, in_dout  : pop side of the upstream first-word-fall-through FIFO
//   out_wr_en, out_full, out_din : push side of the downstream FIFO
//   threshold                    : edge threshold, captured with each frame's first pixel
//   edge_count                   : edge-pixel count of the last completed frame
//   frame_done                   : one-cycle pulse on the write of a frame's last pixel
module edge_threshold
    import edge_pkg::*;
#(
    parameter int         IMG_HEIGHT  = 540,
    parameter int         IMG_WIDTH   = 720,
    parameter bit         BORDER_ZERO = 1'b1,
    parameter logic [7:0] HIGH_VAL    = DEFAULT_HIGH_VAL,
    parameter logic [7:0] LOW_VAL     = DEFAULT_LOW_VAL,
    parameter int         CNT_W       = $clog2(IMG_HEIGHT * IMG_WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             in_rd_en,
    input  logic             in_empty,
    input  logic [7:0]       in_dout,
    output logic             out_wr_en,
    input  logic             out_full,
    output logic [7:0]       out_din,
    input  logic [7:0]       threshold,
    output logic [CNT_W-1:0] edge_count,
    output logic             frame_done
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         thr;
    logic [7:0]         thr_q;
    logic               valid_q;
    logic               last_q;
    logic [7:0]         pix_q;
    logic [CNT_W-1:0]   run_cnt;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               pos_last;
    logic               accept;
    logic               wr_last;
    logic               border;
    logic               high;

    // Strobes are held low during reset so nothing moves while it is asserted.
    assign out_wr_en  = ~reset & valid_q & ~out_full;
    assign in_rd_en   = ~reset & ~in_empty & (~valid_q | ~out_full);
    assign accept     = in_rd_en;
    assign wr_last    = out_wr_en & last_q;
    assign frame_done = wr_last;
    assign out_din    = pix_q;

    raster_counter #(
        .IMG_HEIGHT (IMG_HEIGHT),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_pos (
        .clock (clock),
        .reset (reset),
        .adv   (accept),
        .row   (row),
        .col   (col),
        .last  (pos_last)
    );

    assign border = BORDER_ZERO && is_border(32'(row), 32'(col), IMG_HEIGHT, IMG_WIDTH);
    assign high   = ~border & (in_dout > thr);

    // The first pixel of a frame uses the live threshold; the rest of the
    // frame uses the copy captured alongside it.
    always_comb begin
        state_nx = state;
        thr      = thr_q;
        if (state == S_FIRST) begin
            thr = threshold;
            if (accept) begin
                state_nx = S_BODY;
            end
        end else begin
            if (accept && pos_last) begin
                state_nx = S_FIRST;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FIRST;
            thr_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            pix_q      <= LOW_VAL;
            run_cnt    <= '0;
            edge_count <= '0;
        end else begin
            state <= state_nx;
            if (accept && (state == S_FIRST)) begin
                thr_q <= threshold;
            end

            if (accept) begin
                valid_q <= 1'b1;
                pix_q   <= high ? HIGH_VAL : LOW_VAL;
                last_q  <= pos_last;
            end else if (out_wr_en) begin
                valid_q <= 1'b0;
            end

            // Clear and add in one step so the next frame's first pixel,
            // accepted in the same cycle as the previous frame's last write,
            // is still counted.
            run_cnt <= (wr_last ? '0 : run_cnt) + CNT_W'(accept & high);
            if (wr_last) begin
                edge_count <= run_cnt;
            end
        end
    end

endmodule
